// File: rtl/add8_result_fifo.sv
// add8_result_fifo: show-ahead result FIFO placed after an 8-bit adder.
// Each accepted entry stores the sum with its unsigned carry-out and signed
// overflow flags. The consumer drains entries with a valid/ready handshake.
module add8_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] S,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             ovf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 2;

  // The sum wrapped below operand 0 exactly when the true addition carried out.
  function automatic logic carry_of(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] sum);
    return (sum < a);
  endfunction

  // Signed overflow: both operands share a sign and the sum's sign differs.
  function automatic logic ovf_of(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] sum);
    return (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_sticky_r;

  logic          push_s;
  logic          pop_s;
  logic          in_ovf_s;
  logic [EW-1:0] in_entry_s;
  logic [EW-1:0] head_s;

  // Handshake qualification and the entry formed from the current input.
  always_comb begin
    in_ready   = (count_r != CW'(DEPTH));
    out_valid  = (count_r != {CW{1'b0}});
    push_s     = in_valid && in_ready;
    pop_s      = out_valid && out_ready;
    in_ovf_s   = ovf_of(I0, I1, S);
    in_entry_s = {in_ovf_s, carry_of(I0, S), S};
    head_s     = mem_r[rd_ptr_r];
  end

  // Storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      ovf_sticky_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_entry_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
        if (in_ovf_s) begin
          ovf_sticky_r <= 1'b1;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry fields and status straight from registers (show-ahead).
  always_comb begin
    out_data   = head_s[WIDTH-1:0];
    out_carry  = head_s[WIDTH];
    out_ovf    = head_s[WIDTH+1];
    count      = count_r;
    ovf_sticky = ovf_sticky_r;
  end

endmodule

// File: tb/tb_add8_result_fifo.sv
// Self-checking bench for add8_result_fifo: directed scenarios followed by
// randomized valid/ready traffic against a queue-based reference model.
module tb_add8_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [WIDTH-1:0] I0 = '0;
  logic [WIDTH-1:0] I1 = '0;
  logic [WIDTH-1:0] S = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             ovf_sticky;

  add8_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .S(S),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .ovf_sticky(ovf_sticky)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of {ovf, carry, sum} and sticky flag.
  logic [WIDTH+1:0] mq[$];
  bit               m_sticky = 1'b0;
  bit               last_push = 1'b0;
  int               push_total = 0;
  int               pop_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected entry from plain integer arithmetic on the operands.
  function automatic logic [WIDTH+1:0] model_entry(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    int u;
    int s;
    logic c;
    logic o;
    logic [WIDTH-1:0] sum;
    u   = int'(a) + int'(b);
    s   = int'($signed(a)) + int'($signed(b));
    c   = (u > 255);
    o   = (s > 127) || (s < -128);
    sum = u[WIDTH-1:0];
    return {o, c, sum};
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    I0 = a;
    I1 = b;
    S  = a + b;
    in_valid = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(mq.size()));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    check({tag, "_sticky"}, 32'(ovf_sticky), 32'(m_sticky));
    if (mq.size() != 0) begin
      check({tag, "_head"}, 32'({out_ovf, out_carry, out_data}), 32'(mq[0]));
    end
  endtask

  // One clock: predict the handshakes, advance the model, then compare.
  task automatic cycle(input string tag);
    bit p;
    bit q;
    logic [WIDTH+1:0] e;
    p = in_valid && !RESET && (mq.size() < DEPTH);
    q = out_ready && !RESET && (mq.size() > 0);
    e = model_entry(I0, I1);
    @(posedge CLK);
    if (RESET) begin
      mq.delete();
      m_sticky = 1'b0;
    end else begin
      if (q) begin
        void'(mq.pop_front());
        pop_total++;
      end
      if (p) begin
        mq.push_back(e);
        push_total++;
        if (e[WIDTH+1]) m_sticky = 1'b1;
      end
    end
    last_push = p;
    #1;
    check_state(tag);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cycle("rst");
    RESET = 1'b0;
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_flags", 32'({out_carry, out_ovf}), 32'h0);
  endtask

  initial begin
    // 1: reset then a single push with the consumer stalled
    do_reset();
    check("t1_empty_valid", 32'(out_valid), 32'h0);
    drive(8'h10, 8'h20);
    cycle("t1_push");
    in_valid = 1'b0;
    check("t1_data", 32'(out_data), 32'h30);
    check("t1_flags", 32'({out_carry, out_ovf}), 32'h0);
    check("t1_count", 32'(count), 32'h1);

    // 2: carry entry then overflow entry, drained in order
    do_reset();
    drive(8'hFF, 8'h02);
    cycle("t2_p0");
    check("t2_sticky0", 32'(ovf_sticky), 32'h0);
    drive(8'h7F, 8'h01);
    cycle("t2_p1");
    in_valid = 1'b0;
    check("t2_sticky1", 32'(ovf_sticky), 32'h1);
    check("t2_head0", 32'({out_ovf, out_carry, out_data}), 32'h101);
    out_ready = 1'b1;
    cycle("t2_pop0");
    check("t2_head1", 32'({out_ovf, out_carry, out_data}), 32'h280);
    cycle("t2_pop1");
    out_ready = 1'b0;
    check("t2_drained", 32'(out_valid), 32'h0);

    // 3: fill to full with a fifth value pending, then one pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'(i * 3 + 1), 8'(i + 5));
      cycle("t3_fill");
    end
    drive(8'hA0, 8'h0B);
    check("t3_full_ready", 32'(in_ready), 32'h0);
    check("t3_full_count", 32'(count), 32'h4);
    cycle("t3_hold");
    check("t3_still_full", 32'(count), 32'h4);
    out_ready = 1'b1;
    cycle("t3_pop");
    out_ready = 1'b0;
    check("t3_after_pop", 32'(count), 32'h3);
    check("t3_ready_back", 32'(in_ready), 32'h1);
    cycle("t3_accept5");
    in_valid = 1'b0;
    check("t3_count4", 32'(count), 32'h4);

    // 4: streaming with one entry resident, across pointer wrap
    do_reset();
    drive(8'h01, 8'h01);
    cycle("t4_seed");
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      cycle("t4_stream");
      check("t4_count1", 32'(count), 32'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // 5: reset mid-traffic with a push presented during reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(8'h80, 8'(8'h80 + i));
      cycle("t5_fill");
    end
    check("t5_sticky_set", 32'(ovf_sticky), 32'h1);
    drive(8'h55, 8'h22);
    RESET = 1'b1;
    cycle("t5_rst");
    RESET = 1'b0;
    in_valid = 1'b0;
    check("t5_count", 32'(count), 32'h0);
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_sticky", 32'(ovf_sticky), 32'h0);
    cycle("t5_after");
    check("t5_not_stored", 32'(count), 32'h0);

    // 6: randomized traffic; inputs held stable until accepted
    do_reset();
    push_total = 0;
    pop_total = 0;
    begin
      int cyc;
      cyc = 0;
      while ((push_total < 1000 || mq.size() != 0) && cyc < 20000) begin
        if (!in_valid || last_push) begin
          if (push_total < 1000 && $urandom_range(0, 3) != 0) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 2) != 0);
        cycle("t6");
        cyc++;
      end
      check("t6_timeout", 32'(cyc < 20000), 32'h1);
      check("t6_pushes", 32'(push_total), 32'd1000);
      check("t6_pops", 32'(pop_total), 32'd1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add8_result_fifo.md
Name: add8_result_fifo

Overview:
- Elastic output stage that sits directly downstream of the 8-bit combinational adder wrapper.
- Captures the adder's operands and sum, derives unsigned carry-out and signed overflow, and holds results in a small show-ahead FIFO.
- A consumer drains the FIFO with a valid/ready handshake, which decouples adder producers from stalling consumers.

Parameters:
- WIDTH, 8, data width of operands and sum.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- CW, 3, count width = log2(DEPTH)+1.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I0  in  WIDTH  adder operand 0, as fed to the adder.
- I1  in  WIDTH  adder operand 1, as fed to the adder.
- S  in  WIDTH  adder sum O, modulo 2^WIDTH.
- in_valid  in  1  producer has a valid I0/I1/S triple.
- in_ready  out  1  FIFO can accept this cycle.
- out_data  out  WIDTH  head-entry sum.
- out_carry  out  1  head-entry unsigned carry-out.
- out_ovf  out  1  head-entry signed overflow.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head this cycle.
- count  out  CW  occupied entries, 0..DEPTH.
- ovf_sticky  out  1  set once any accepted entry had signed overflow.

Behaviour:
Interface decision:
- One clock (CLK). Reset (RESET) is synchronous and active-high.

Handshakes:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Producer must hold I0/I1/S/in_valid stable until push; the consumer side follows the same rule.

Derived flags, computed combinationally at the input and stored with the entry:
- carry = (S < I0), unsigned compare. Equivalent to the true carry-out of I0+I1 truncated to WIDTH.
- ovf = (I0[W-1] == I1[W-1]) & (S[W-1] != I0[W-1]).
- Stored entry = {ovf, carry, S}, WIDTH+2 bits.

Storage:
- DEPTH-entry register array, wr_ptr and rd_ptr of log2(DEPTH) bits, and a count register.
- Pointers wrap modulo DEPTH naturally, with no special-case logic.

Ready, valid and latency:
- in_ready = (count != DEPTH). It is combinational from the count register only; there is no dependence on out_ready, so a full FIFO cannot accept on the same cycle it pops.
- out_valid = (count != 0).
- out_data, out_carry and out_ovf come from mem[rd_ptr] (show-ahead). They are undefined-free: all entries are cleared on reset.
- Latency: a push in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty. There is no combinational input-to-output path.

Count update:
- push only: count+1.
- pop only: count-1.
- push and pop together (only possible when 0 < count < DEPTH): count unchanged, both pointers advance.

Boundaries:
- Pop while empty is impossible, since out_valid=0.
- Push while full is impossible, since in_ready=0.
- out_data is stable while out_valid=1 and out_ready=0.

ovf_sticky:
- Set on the cycle after a push whose ovf=1.
- Cleared only by RESET.

Reset (RESET=1 at a rising edge):
- wr_ptr, rd_ptr, count and all mem entries go to 0, and ovf_sticky goes to 0.
- The cycle after reset: out_valid=0, in_ready=1, out_data=0, out_carry=0, out_ovf=0, count=0.
- Reset mid-traffic discards all stored entries. A push or pop presented in the reset cycle is ignored.

Test Plan:
1. Reset, then push I0=0x10, I1=0x20, S=0x30 with out_ready=0 -> next cycle out_valid=1, out_data=0x30, carry=0, ovf=0, count=1.
2. Push I0=0xFF, I1=0x02, S=0x01, then I0=0x7F, I1=0x01, S=0x80 -> entries pop in order: (0x01, carry=1, ovf=0), then (0x80, carry=0, ovf=1); ovf_sticky=1 from the cycle after the second push.
3. Hold out_ready=0 and push 5 values -> after 4 accepts in_ready=0 and count=4; the 5th stays pending. Raise out_ready for 1 cycle -> 0x.. head pops, count=3, in_ready=1 the next cycle, and the 5th is accepted after that.
4. Continuous in_valid=1 and out_ready=1 with count=1 -> one push and one pop per cycle, count stays 1, data order is preserved across pointer wrap (≥10 entries).
5. Fill 3 entries, assert RESET for 1 cycle while in_valid=1 -> count=0, out_valid=0, ovf_sticky=0, and the input presented during reset is not stored.
6. Randomized valid/ready, 1000 transactions, against a reference queue model -> no loss, no duplication, and correct carry/ovf per entry.
